// File: rtl/dbuf_write_ctrl.sv
// dbuf_write_ctrl
// Write-side controller for a ping-pong double buffer in the clk_a domain.
// It takes full-width pixel words over a valid/ready handshake and drives
// the port-A address, data and per-buffer write enables. Each completed
// frame is published to the clk_b reader with a request toggle. The
// buffers swap when the reader returns an acknowledge toggle.
//
// Ports:
//   clk_a, rst_n        write clock; synchronous active-low reset
//   I_valid / O_ready   input word handshake
//   I_sof               start-of-frame, qualified by I_valid
//   I_data_flat         input word, one BLOCK_DATA_WIDTH_A lane per block
//   O_ada, O_din_flat   port-A address / data shared by all blocks
//   O_wea               write enable, bit 0 -> buffer 0, bit 1 -> buffer 1
//   O_wr_sel, O_rd_sel  buffer being written / buffer published to reader
//   O_swap_req_toggle   inverts once per completed frame
//   I_swap_ack_toggle   reader acknowledge toggle (asynchronous, clk_b)
//   O_frame_count       completed frames, wrapping
//   O_drop_count        words discarded while waiting (DBUF_DROP_FRAME_EN)
//
// Optional feature macro: DBUF_DROP_FRAME_EN. When it is defined, the
// controller keeps accepting words while it waits for the acknowledge and
// discards them instead of applying back-pressure.
module dbuf_write_ctrl #(
  parameter int BYTES_PER_BLOCK    = 2250,
  parameter int BANK_COUNT         = 6,
  parameter int BLOCK_COUNT        = 2,
  parameter int BLOCK_DATA_WIDTH_A = 32,
  localparam int DATA_COUNT = BANK_COUNT * BLOCK_COUNT,
  localparam int ADDR_COUNT = (BYTES_PER_BLOCK * 8) / BLOCK_DATA_WIDTH_A,
  localparam int AW         = $clog2(ADDR_COUNT),
  localparam int DW         = DATA_COUNT * BLOCK_DATA_WIDTH_A
) (
  input  logic          clk_a,
  input  logic          rst_n,
  input  logic          I_valid,
  output logic          O_ready,
  input  logic          I_sof,
  input  logic [DW-1:0] I_data_flat,
  output logic [AW-1:0] O_ada,
  output logic [DW-1:0] O_din_flat,
  output logic [1:0]    O_wea,
  output logic          O_wr_sel,
  output logic          O_rd_sel,
  output logic          O_swap_req_toggle,
  input  logic          I_swap_ack_toggle,
  output logic [15:0]   O_frame_count
`ifdef DBUF_DROP_FRAME_EN
  ,
  output logic [15:0]   O_drop_count
`endif
);

  localparam logic [0:0] S_WRITE    = 1'b0;
  localparam logic [0:0] S_WAIT_ACK = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(ADDR_COUNT - 1);

  logic [0:0]    r_state;
  logic [AW-1:0] r_wcnt;
  logic [1:0]    r_wea;
  logic [AW-1:0] r_ada;
  logic [DW-1:0] r_din;
  logic          r_wr_sel;
  logic          r_rd_sel;
  logic          r_req_tog;
  logic [15:0]   r_frame_cnt;
  logic          r_ack_s1;
  logic          r_ack_s2;
  logic          r_ack_s3;

  logic w_accept;
  logic w_write;
  logic w_ack_pulse;

`ifdef DBUF_DROP_FRAME_EN
  logic [15:0] r_drop_cnt;
  logic        w_drop;

  // Ready stays high while waiting; those words are accepted and discarded.
  assign O_ready = rst_n;
  assign w_drop  = w_accept && (r_state == S_WAIT_ACK);
`else
  assign O_ready = rst_n && (r_state == S_WRITE);
`endif

  assign w_accept    = I_valid && O_ready;
  assign w_write     = w_accept && (r_state == S_WRITE);
  // Edge detect on the synchronized acknowledge toggle.
  assign w_ack_pulse = r_ack_s2 ^ r_ack_s3;

  // Stage: acknowledge synchronizer (two flops plus edge-detect flop).
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_s3 <= 1'b0;
    end else begin
      r_ack_s1 <= I_swap_ack_toggle;
      r_ack_s2 <= r_ack_s1;
      r_ack_s3 <= r_ack_s2;
    end
  end

  // Stage: accept -> port-A write, one cycle later.
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_state     <= S_WRITE;
      r_wcnt      <= '0;
      r_wea       <= 2'b00;
      r_ada       <= '0;
      r_din       <= '0;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b1;
      r_req_tog   <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_wea <= 2'b00;
      if (w_write) begin
        r_wea <= r_wr_sel ? 2'b10 : 2'b01;
        r_din <= I_data_flat;
        if (I_sof) begin
          // Resynchronize: abandon any partial frame without publishing.
          r_ada  <= '0;
          r_wcnt <= AW'(1);
        end else begin
          r_ada <= r_wcnt;
          if (r_wcnt == LAST_ADDR) begin
            r_wcnt      <= '0;
            r_req_tog   <= ~r_req_tog;
            r_rd_sel    <= r_wr_sel;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= S_WAIT_ACK;
          end else begin
            r_wcnt <= r_wcnt + AW'(1);
          end
        end
      end
      // An acknowledge outside WAIT_ACK is stale and is ignored.
      if ((r_state == S_WAIT_ACK) && w_ack_pulse) begin
        r_wr_sel <= ~r_wr_sel;
        r_state  <= S_WRITE;
      end
    end
  end

`ifdef DBUF_DROP_FRAME_EN
  always_ff @(posedge clk_a) begin
    if (!rst_n) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign O_drop_count = r_drop_cnt;
`endif

  assign O_ada             = r_ada;
  assign O_din_flat        = r_din;
  assign O_wea             = r_wea;
  assign O_wr_sel          = r_wr_sel;
  assign O_rd_sel          = r_rd_sel;
  assign O_swap_req_toggle = r_req_tog;
  assign O_frame_count     = r_frame_cnt;

endmodule

// File: doc/dbuf_write_ctrl.md
Name: dbuf_write_ctrl

Overview:
- Write-side controller for the ping-pong double buffer built from two Single_Buffer instances (buffer 0 and buffer 1) in the clk_a domain.
- Accepts full-width pixel words from the HDMI capture path over a valid/ready handshake and generates the port-A address, data and per-buffer write enables.
- Publishes each completed frame to the clk_b read side with a toggle request. Swaps buffers when the read side returns a toggle acknowledge.

Parameters:
- BYTES_PER_BLOCK, 2250, bytes stored per BRAM block.
- BANK_COUNT, 6, banks per buffer.
- BLOCK_COUNT, 2, blocks per bank.
- BLOCK_DATA_WIDTH_A, 32, port-A word width per block.
- Derived (localparam, not overridable):
  - DATA_COUNT = BANK_COUNT*BLOCK_COUNT.
  - ADDR_COUNT = (BYTES_PER_BLOCK*8)/BLOCK_DATA_WIDTH_A. Default 562, integer division.
  - AW = $clog2(ADDR_COUNT).

Ports:
- clk_a  in  1  write clock.
- rst_n  in  1  reset, synchronous, active-low, clock clk_a.
- I_valid  in  1  input word valid.
- O_ready  out  1  controller can accept a word.
- I_sof  in  1  start-of-frame; qualified by I_valid.
- I_data_flat  in  DATA_COUNT*BLOCK_DATA_WIDTH_A  input word, one lane per block.
- O_ada  out  AW  port-A address, common to all blocks.
- O_din_flat  out  DATA_COUNT*BLOCK_DATA_WIDTH_A  port-A write data.
- O_wea  out  2  write enable. Bit 0 drives buffer 0, bit 1 drives buffer 1.
- O_wr_sel  out  1  buffer currently being written.
- O_rd_sel  out  1  buffer published to the reader.
- O_swap_req_toggle  out  1  toggles once per completed frame.
- I_swap_ack_toggle  in  1  reader acknowledge, clk_b domain, asynchronous.
- O_frame_count  out  16  number of completed frames; wraps.

Behaviour:
- States:
  - WRITE: O_ready=1.
  - WAIT_ACK: O_ready=0.
  - O_ready is combinational from the state and is 0 while rst_n=0.
- Accept: a word is accepted when I_valid & O_ready on a clk_a edge.
- Write pipeline, 1 cycle latency: a word accepted at edge N produces the following from N+1 until the next edge:
  - O_wea bit O_wr_sel = 1,
  - O_ada = word counter value,
  - O_din_flat = captured data.
  - O_wea = 0 in every other cycle.
- Word counter wcnt (AW bits):
  - Increments on each accept.
  - Accept with I_sof=1: the word is written to address 0 and wcnt becomes 1, discarding any partial frame with no publish.
  - A word without I_sof at wcnt=0 is accepted normally.
- Frame complete: accept at wcnt=ADDR_COUNT-1. On that edge:
  - wcnt <= 0,
  - O_swap_req_toggle inverts,
  - O_rd_sel <= O_wr_sel,
  - O_frame_count increments, wrapping 0xFFFF->0,
  - state <= WAIT_ACK.
  - The final word's write still issues on the following cycle.
- Ack synchronizer:
  - I_swap_ack_toggle passes through two flops, then an edge detector against a third flop. All three reset to 0.
  - ack_pulse is seen 3 clk_a edges after the input changes.
- WAIT_ACK on ack_pulse: O_wr_sel inverts, state <= WRITE, O_ready=1 in the next cycle.
- ack_pulse in WRITE (spurious or stale): ignored, no state change.
- I_sof in WAIT_ACK: not accepted because O_ready=0. The source holds it.
- Reset values while rst_n=0:
  - state WRITE (held not-ready), wcnt=0, O_wea=0, O_ada=0, O_din_flat=0,
  - O_wr_sel=0, O_rd_sel=1, O_swap_req_toggle=0, O_frame_count=0, synchronizer flops=0.
- Reset mid-frame: the partial frame is abandoned, all state returns to reset values, and the pending write pipeline stage is cleared.

Optional Feature:
- Macro DBUF_DROP_FRAME_EN.
- Defined:
  - In WAIT_ACK, O_ready stays 1. Accepted words are discarded with O_wea=0.
  - Adds output O_drop_count (16 bits, saturating at 0xFFFF, reset 0), incremented per discarded word.
  - An I_sof accepted in WAIT_ACK is also discarded.
  - On ack_pulse, writing restarts at address 0.
- Not defined: O_ready=0 in WAIT_ACK (back-pressure) and the O_drop_count port is absent.

Test Plan:
- Reset: hold rst_n=0 for 10 cycles -> O_ready=0, O_wea=0, O_wr_sel=0, O_rd_sel=1, O_swap_req_toggle=0, O_frame_count=0. O_ready=1 in the first cycle after release.
- Full frame: 562 accepted words with lane i = k+i and I_sof on k=0 -> O_ada 0..561, O_wea=2'b01, each one cycle after accept. After k=561: O_ready=0, toggle=1, O_rd_sel=0, O_frame_count=1.
- Swap: drive I_swap_ack_toggle 0->1 in WAIT_ACK -> O_wr_sel=1 and O_ready=1 within 3-4 clk_a cycles. The next frame writes with O_wea=2'b10. The second completion gives toggle=0, O_rd_sel=1.
- Resync: I_sof asserted on word k=100 -> that word is written at O_ada=0. 561 further words are needed before the toggle changes. O_frame_count is unchanged at the abort.
- Stall: I_valid held 50 cycles in WAIT_ACK -> no O_wea, O_ready=0. With DBUF_DROP_FRAME_EN: O_ready=1, O_wea=0, O_drop_count=50.
- Mid-frame reset at k=300 -> all reset values restored. The next accepted word is written at O_ada=0 into buffer 0.
